// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined carry-segmented adder.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
// Contents: saturation mode constants, a configuration check and the
// signed max/min pattern helpers used by the saturation mux.
package pipelined_adder_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Widest operand the pattern helpers can describe.
    localparam int MAX_WIDTH = 64;

    // True when the operand splits evenly into one segment per stage.
    function automatic bit width_ok(input int width, input int stages);
        return (stages > 0) && (width > 0) && (width <= MAX_WIDTH)
            && ((width % stages) == 0);
    endfunction

    // 0111..1 for a width-bit two's-complement value, right-aligned.
    function automatic logic [MAX_WIDTH-1:0] signed_max(input int width);
        return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
    endfunction

    // 1000..0 for a width-bit two's-complement value, right-aligned.
    function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/pipelined_adder_segment.sv
// One SEG-bit ripple-carry slice built from full-adder cells.
// Latency: purely combinational.
// Backpressure: none; the caller registers around it.
// Ports: a, b, cin in; s (sum), cout (carry out of top bit),
// cmsb (carry into top bit, XORed with cout to form signed overflow).
module adder_segment
    import pipelined_adder_pkg::*;
#(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           cmsb
);

    logic [SEG:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SEG];
    assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined carry-segmented adder: WIDTH-bit a+b+carry_in, one SEG-bit slice per stage.
// Latency: STAGES cycles from the accepting edge to registered outputs.
// Backpressure: one global advance; out_valid && !out_ready freezes every stage and drops in_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, carry_in;
// out_valid/out_ready with sum (wrapped or saturated), carry_out (raw), overflow.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int SAT    = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SEG = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] SUM_MAX = WIDTH'(signed_max(WIDTH));
    localparam logic [WIDTH-1:0] SUM_MIN = WIDTH'(signed_min(WIDTH));

    if (!width_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
    end

    logic             adv;
    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_out_d, carry_out_q;
    logic             overflow_d, overflow_q;

    // Single advance signal for the whole pipe: any stall freezes every stage,
    // so slots never collide and ordering is trivially preserved.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // Stages 0..STAGES-2: each adds its own slice, passes the carry, keeps the
    // finished low bits (de-skew) and the untouched high operand bits (skew).
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_stg
        localparam int LO = (k + 1) * SEG;   // result bits complete after this stage
        localparam int HI = WIDTH - LO;      // operand bits still to be added

        logic [HI+SEG-1:0] src_a, src_b;
        logic              src_cin, src_vld;
        logic [LO-1:0]     res_new;
        logic [SEG-1:0]    seg_s;
        logic              seg_cout, unused_cmsb;

        logic          vld_d, vld_q;
        logic          cy_d, cy_q;
        logic [LO-1:0] res_d, res_q;
        logic [HI-1:0] opa_d, opa_q, opb_d, opb_q;

        if (k == 0) begin : g_src
            assign src_a   = a;
            assign src_b   = b;
            assign src_cin = carry_in;
            assign src_vld = in_valid;
            assign res_new = seg_s;
        end else begin : g_src
            assign src_a   = g_stg[k-1].opa_q;
            assign src_b   = g_stg[k-1].opb_q;
            assign src_cin = g_stg[k-1].cy_q;
            assign src_vld = g_stg[k-1].vld_q;
            assign res_new = {seg_s, g_stg[k-1].res_q};
        end

        adder_segment #(.SEG(SEG)) u_seg (
            .a    (src_a[SEG-1:0]),
            .b    (src_b[SEG-1:0]),
            .cin  (src_cin),
            .s    (seg_s),
            .cout (seg_cout),
            .cmsb (unused_cmsb)
        );

        always_comb begin
            vld_d = vld_q;
            cy_d  = cy_q;
            res_d = res_q;
            opa_d = opa_q;
            opb_d = opb_q;
            if (adv) begin
                vld_d = src_vld;
                // Data only moves with a real operation; bubbles leave it parked.
                if (src_vld) begin
                    cy_d  = seg_cout;
                    res_d = res_new;
                    opa_d = src_a[HI+SEG-1:SEG];
                    opb_d = src_b[HI+SEG-1:SEG];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                res_q <= '0;
                opa_q <= '0;
                opb_q <= '0;
            end else begin
                vld_q <= vld_d;
                cy_q  <= cy_d;
                res_q <= res_d;
                opa_q <= opa_d;
                opb_q <= opb_d;
            end
        end
    end

    // Final slice: adds the top segment, forms overflow, applies saturation.
    logic [SEG-1:0]   fin_a, fin_b, fin_s;
    logic             fin_cin, fin_vld, fin_cout, fin_cmsb, fin_ovf;
    logic [WIDTH-1:0] fin_raw, fin_sum;

    if (STAGES == 1) begin : g_fin
        assign fin_a   = a;
        assign fin_b   = b;
        assign fin_cin = carry_in;
        assign fin_vld = in_valid;
        assign fin_raw = fin_s;
    end else begin : g_fin
        assign fin_a   = g_stg[STAGES-2].opa_q;
        assign fin_b   = g_stg[STAGES-2].opb_q;
        assign fin_cin = g_stg[STAGES-2].cy_q;
        assign fin_vld = g_stg[STAGES-2].vld_q;
        assign fin_raw = {fin_s, g_stg[STAGES-2].res_q};
    end

    adder_segment #(.SEG(SEG)) u_seg_fin (
        .a    (fin_a),
        .b    (fin_b),
        .cin  (fin_cin),
        .s    (fin_s),
        .cout (fin_cout),
        .cmsb (fin_cmsb)
    );

    assign fin_ovf = fin_cout ^ fin_cmsb;

    // On overflow both operands share a sign, so a's MSB picks the clamp direction.
    always_comb begin
        fin_sum = fin_raw;
        if ((SAT == MODE_SAT) && fin_ovf) begin
            fin_sum = fin_a[SEG-1] ? SUM_MIN : SUM_MAX;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        if (adv) begin
            out_valid_d = fin_vld;
            if (fin_vld) begin
                sum_d       = fin_sum;
                carry_out_d = fin_cout;
                overflow_d  = fin_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: 16-bit/4-stage wrap and saturating instances in lockstep,
// plus an 8-bit single-stage saturating instance for the degenerate config.
module tb_pipelined_adder;

    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, out_ready, carry_in;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, carry_out, overflow;
    logic [W-1:0] sum;
    logic         in_ready_s, out_valid_s, carry_out_s, overflow_s;
    logic [W-1:0] sum_s;

    logic         in_valid8, out_ready8, carry_in8;
    logic [7:0]   a8, b8, sum8;
    logic         in_ready8, out_valid8, carry_out8, overflow8;

    pipelined_adder #(.WIDTH(W), .STAGES(N), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    pipelined_adder #(.WIDTH(W), .STAGES(N), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid_s),
        .out_ready(out_ready), .sum(sum_s), .carry_out(carry_out_s), .overflow(overflow_s)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1), .SAT(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .carry_in(carry_in8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .carry_out(carry_out8), .overflow(overflow8)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        int          acc;
        bit          lat;
    } op_t;

    op_t sb[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    endtask

    // Reference: {overflow, carry_out, sum}
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input bit sat);
        logic [16:0] r;
        logic        ovf;
        logic [15:0] s;
        r   = {1'b0, x} + {1'b0, y} + {16'd0, c};
        ovf = (x[15] == y[15]) && (r[15] != x[15]);
        s   = r[15:0];
        if (sat && ovf) s = x[15] ? 16'h8000 : 16'h7FFF;
        return {ovf, r[16], s};
    endfunction

    // Output monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        op_t         e;
        logic [17:0] m0, m1;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                e  = sb.pop_front();
                m0 = model(e.a, e.b, e.cin, 1'b0);
                m1 = model(e.a, e.b, e.cin, 1'b1);
                check("wrap_sum",  32'(sum),         32'(m0[15:0]));
                check("wrap_cout", 32'(carry_out),   32'(m0[16]));
                check("wrap_ovf",  32'(overflow),    32'(m0[17]));
                check("sat_vld",   32'(out_valid_s), 32'd1);
                check("sat_sum",   32'(sum_s),       32'(m1[15:0]));
                check("sat_cout",  32'(carry_out_s), 32'(m1[16]));
                check("sat_ovf",   32'(overflow_s),  32'(m1[17]));
                if (e.lat) check("latency", 32'(cyc - e.acc), 32'(N));
            end
        end
    end

    // Drive one operation; called just after a rising edge, returns just after the accepting edge.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c, input bit lat);
        op_t e;
        int  t;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        carry_in = c;
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'd1, 32'd0);
        end else begin
            e.a = x; e.b = y; e.cin = c; e.acc = cyc; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Hold out_ready low for 3 cycles once a result is presented.
    task automatic stall3();
        int          t;
        logic [15:0] hs;
        logic        hc, ho;
        t = 0;
        @(posedge clk);
        #1;
        while (!out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("stall_reached", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        hs = sum; hc = carry_out; ho = overflow;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready),  32'd0);
            check("stall_valid",    32'(out_valid), 32'd1);
            check("stall_sum",      32'(sum),       32'(hs));
            check("stall_cout",     32'(carry_out), 32'(hc));
            check("stall_ovf",      32'(overflow),  32'(ho));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ghosts;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; carry_in8 = 1'b0; out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_sum",       32'(sum),        32'd0);
        check("rst_cout",      32'(carry_out),  32'd0);
        check("rst_ovf",       32'(overflow),   32'd0);
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_s1_valid",  32'(out_valid8), 32'd0);
        @(posedge clk);
        #1;

        // Latency and order: 8 back-to-back operations
        for (int i = 0; i < 8; i++) send(16'(i), 16'(i * 256), 1'b0, 1'b1);
        wait_drain();

        // Carry ripple and overflow corners
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        send(16'h8000, 16'hFFFF, 1'b0, 1'b0);
        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        wait_drain();

        // Backpressure with random traffic
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            end
            stall3();
        join
        wait_drain();

        // Reset mid-flight; the operation offered during reset must be dropped
        for (int i = 0; i < 3; i++) send(16'(16'h1111 * (i + 1)), 16'h0101, 1'b0, 1'b0);
        rst = 1'b1; in_valid = 1'b1; a = 16'h5555; b = 16'h2222;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_sum",       32'(sum),       32'd0);
        check("rst2_cout",      32'(carry_out), 32'd0);
        check("rst2_ovf",       32'(overflow),  32'd0);
        check("rst2_in_ready",  32'(in_ready),  32'd1);
        ghosts = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid || out_valid_s) ghosts++;
        end
        check("rst_no_ghost", 32'(ghosts), 32'd0);
        @(posedge clk);
        #1;
        send(16'h0F0F, 16'h1010, 1'b1, 1'b1);
        wait_drain();

        // Degenerate config: 8-bit, single stage, saturating
        in_valid8 = 1'b1; a8 = 8'h40; b8 = 8'h40;
        @(negedge clk);
        check("s1_no_comb",  32'(out_valid8), 32'd0);
        check("s1_in_ready", 32'(in_ready8),  32'd1);
        @(posedge clk);
        #1;
        a8 = 8'h80; b8 = 8'hFF;
        @(negedge clk);
        check("s1_valid_a", 32'(out_valid8), 32'd1);
        check("s1_sum_a",   32'(sum8),       32'h7F);
        check("s1_ovf_a",   32'(overflow8),  32'd1);
        check("s1_cout_a",  32'(carry_out8), 32'd0);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        check("s1_valid_b", 32'(out_valid8), 32'd1);
        check("s1_sum_b",   32'(sum8),       32'h80);
        check("s1_ovf_b",   32'(overflow8),  32'd1);
        check("s1_cout_b",  32'(carry_out8), 32'd1);
        @(negedge clk);
        check("s1_bubble",  32'(out_valid8), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
